cla_adder_64: RTL and testbench

64-bit two-level carry-lookahead adder with optional output register, used as the wide add/increment datapath element in the arithmetic units. Computes a + b + cin with full group generate/propagate lookahead: no ripple path across 4-bit groups, 16-bit blocks or the 64-bit word. A valid strobe travels with the data so the block drops into either a combinational or a registered pipeline slot.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_group_4.sv | 30 +++
 rtl/cla_adder_64.sv | 85 ++++++++
 tb/tb_cla_adder_64.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and the generate/propagate pair type for the 64-bit
// two-level carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH   = 64;
  localparam int CLA_GROUP   = 4;
  localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;    // 16 bit-level groups
  localparam int CLA_NBLOCKS = CLA_NGROUPS / CLA_GROUP;  // 4 blocks of 16 bits

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t make_gp(input logic x, input logic y);
    gp_t r;
    r.g = x & y;
    r.p = x ^ y;
    return r;
  endfunction

endpackage

// File: rtl/cla_group_4.sv
// 4-wide lookahead cell: flattened sum-of-products carries from a group
// carry-in, plus group generate/propagate. Reused at bit, block and top level.
module cla_group_4
  import cla_pkg::*;
(
  input  gp_t  [CLA_GROUP-1:0] gp,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] c,
  output gp_t                  gp_out
);

  // Carries are two-level SOP in cin, so no ripple through the cell.
  assign c[0] = cin;
  assign c[1] = gp[0].g
              | (gp[0].p & cin);
  assign c[2] = gp[1].g
              | (gp[1].p & gp[0].g)
              | (gp[1].p & gp[0].p & cin);
  assign c[3] = gp[2].g
              | (gp[2].p & gp[1].g)
              | (gp[2].p & gp[1].p & gp[0].g)
              | (gp[2].p & gp[1].p & gp[0].p & cin);

  assign gp_out.g = gp[3].g
                  | (gp[3].p & gp[2].g)
                  | (gp[3].p & gp[2].p & gp[1].g)
                  | (gp[3].p & gp[2].p & gp[1].p & gp[0].g);
  assign gp_out.p = gp[3].p & gp[2].p & gp[1].p & gp[0].p;

endmodule

// File: rtl/cla_adder_64.sv
// 64-bit two-level carry-lookahead adder (a + b + cin) with a valid strobe.
// Define CLA64_OUTPUT_REG_EN to register sum/cout/valid_out (1-cycle latency).
module cla_adder_64
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 cin,
  input  logic                 valid_in,
  output logic [CLA_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 valid_out
);

  gp_t  [CLA_WIDTH-1:0]   bit_gp;
  logic [CLA_WIDTH-1:0]   carry;
  gp_t  [CLA_NGROUPS-1:0] grp_gp;
  logic [CLA_NGROUPS-1:0] grp_c;
  gp_t  [CLA_NBLOCKS-1:0] blk_gp;
  logic [CLA_NBLOCKS-1:0] blk_c;
  gp_t                    top_gp;
  logic [CLA_WIDTH-1:0]   sum_c;
  logic                   cout_c;

  for (genvar i = 0; i < CLA_WIDTH; i++) begin : g_bit
    assign bit_gp[i] = make_gp(a[i], b[i]);
    assign sum_c[i]  = bit_gp[i].p ^ carry[i];
  end

  // Level 1: 16 groups turn group carry-ins into bit carries.
  for (genvar j = 0; j < CLA_NGROUPS; j++) begin : g_grp
    cla_group_4 u_grp (
      .gp     (bit_gp[CLA_GROUP*j +: CLA_GROUP]),
      .cin    (grp_c[j]),
      .c      (carry[CLA_GROUP*j +: CLA_GROUP]),
      .gp_out (grp_gp[j])
    );
  end

  // Level 2: 4 blocks turn block carry-ins into group carry-ins.
  for (genvar k = 0; k < CLA_NBLOCKS; k++) begin : g_blk
    cla_group_4 u_blk (
      .gp     (grp_gp[CLA_GROUP*k +: CLA_GROUP]),
      .cin    (blk_c[k]),
      .c      (grp_c[CLA_GROUP*k +: CLA_GROUP]),
      .gp_out (blk_gp[k])
    );
  end

  // Level 3: word-level lookahead from cin gives the block carry-ins.
  cla_group_4 u_top (
    .gp     (blk_gp),
    .cin    (cin),
    .c      (blk_c),
    .gp_out (top_gp)
  );

  assign cout_c = top_gp.g | (top_gp.p & cin);

`ifdef CLA64_OUTPUT_REG_EN
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      sum       <= sum_c;
      cout      <= cout_c;
      valid_out <= valid_in;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign sum       = sum_c;
  assign cout      = cout_c;
  assign valid_out = valid_in;
`endif

endmodule

// File: tb/tb_cla_adder_64.sv
// Directed and random checks for cla_adder_64; adapts to either build
// through CLA64_OUTPUT_REG_EN.
module tb_cla_adder_64;
  import cla_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [CLA_WIDTH-1:0] a   = '0;
  logic [CLA_WIDTH-1:0] b   = '0;
  logic                 cin = 1'b0;
  logic                 valid_in = 1'b0;
  logic [CLA_WIDTH-1:0] sum;
  logic                 cout;
  logic                 valid_out;

  int checks = 0;
  int errors = 0;

  cla_adder_64 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .valid_in  (valid_in),
    .sum       (sum),
    .cout      (cout),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] actual,
                       input logic [64:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance to the point where outputs reflect the inputs just driven.
  task automatic settle;
`ifdef CLA64_OUTPUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic add_check(input string tag, input logic [63:0] x,
                           input logic [63:0] y, input logic ci,
                           input logic [63:0] exp_sum, input logic exp_cout);
    a = x; b = y; cin = ci; valid_in = 1'b1;
    settle();
    check(tag, {cout, sum}, {exp_cout, exp_sum});
    check({tag, "_valid"}, 65'(valid_out), 65'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_q [$];
    logic [64:0] ref_v;
    logic [64:0] prev;

    // Reset state with idle inputs.
    settle();
    check("reset_idle_data", {cout, sum}, 65'd0);
    check("reset_idle_valid", 65'(valid_out), 65'd0);

    // Reset asserted together with a valid add: reset wins in registered build.
    a = 64'd5; b = 64'd7; cin = 1'b0; valid_in = 1'b1;
    settle();
`ifdef CLA64_OUTPUT_REG_EN
    check("reset_with_valid_data", {cout, sum}, 65'd0);
    check("reset_with_valid_valid", 65'(valid_out), 65'd0);
`else
    check("reset_with_valid_data", {cout, sum}, 65'd12);
    check("reset_with_valid_valid", 65'(valid_out), 65'd1);
`endif
    rst = 1'b0;
    settle();
    check("first_after_reset_data", {cout, sum}, 65'd12);
    check("first_after_reset_valid", 65'(valid_out), 65'd1);

    // Directed carry-boundary vectors.
    add_check("no_carry",   64'hE, 64'h1, 1'b0, 64'hF, 1'b0);
    add_check("nibble",     64'hF, 64'h1, 1'b0, 64'h10, 1'b0);
    add_check("byte",       64'hFF, 64'h1, 1'b0, 64'h100, 1'b0);
    add_check("group3",     64'hFFF, 64'h1, 1'b0, 64'h1000, 1'b0);
    add_check("block",      64'hFFFF, 64'h1, 1'b0, 64'h1_0000, 1'b0);
    add_check("two_blocks", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
              64'h0000_0001_0000_0000, 1'b0);
    add_check("three_blocks", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h0001_0000_0000_0000, 1'b0);
    add_check("wrap_b1",    64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
    add_check("wrap_cin",   64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
    add_check("msb_pair",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              1'b0, 64'h0, 1'b1);
    add_check("mixed",      64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              1'b0, 64'h2222_2222_2222_2211, 1'b0);
    add_check("mixed_cin",  64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              1'b1, 64'h2222_2222_2222_2212, 1'b0);

    // valid_in low must not gate the arithmetic.
    a = 64'd3; b = 64'd4; cin = 1'b1; valid_in = 1'b0;
    settle();
    check("invalid_data", {cout, sum}, 65'd8);
    check("invalid_valid", 65'(valid_out), 65'd0);

`ifdef CLA64_OUTPUT_REG_EN
    // Back-to-back stream: output holds until the edge, then shows that
    // cycle's result, in order.
    prev = {cout, sum};
    for (int i = 0; i < 8; i++) begin
      a = 64'h1111_1111_1111_1111 * 64'(i + 1);
      b = 64'hFFFF_0000_FFFF_0000 >> i;
      cin = i[0];
      valid_in = 1'b1;
      exp_q.push_back(a);
      ref_v = {1'b0, a} + {1'b0, b} + 65'(cin);
      #2;
      check("stream_hold", {cout, sum}, prev);
      @(posedge clk);
      #1;
      check("stream_result", {cout, sum}, ref_v);
      check("stream_valid", 65'(valid_out), 65'd1);
      prev = ref_v;
    end
`endif

    // Random vectors against a 65-bit reference.
    for (int i = 0; i < 2000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom);
      valid_in = 1'b1;
      ref_v = {1'b0, a} + {1'b0, b} + 65'(cin);
      settle();
      check("random", {cout, sum}, ref_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
